uart_autobaud: RTL and testbench
================================

# uart_autobaud

Receive-side front end placed between the raw RXD pad and `uart_rx`. It synchronises and glitch-filters the asynchronous pad input to produce `rxd_in`, and owns the `baud_rate_param` register. On request it measures the bit period from a received 0x55 sync character (8N1, LSB first) and writes the matching `baud_rate_param`. While measuring it holds `uart_rx` off via `rx_hold`, which is ORed into `uart_disable`.

## Interface
- `DEFAULT_PARAM`, 16'd433: reset value of `baud_rate_param`. Bit period is `baud_rate_param + 1` clocks.
- `MIN_PARAM`, 16'd7: smallest acceptable measured `baud_rate_param`.
- `clk`  in  1  system clock; the block has one clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `rxd_pad`  in  1  raw asynchronous serial input.
- `param_wr`  in  1  software write strobe for `baud_rate_param`. Ignored while `abr_busy`.
- `param_wdata`  in  16  software write data.
- `abr_start`  in  1  one-cycle pulse that arms a measurement. Ignored while `abr_busy`.
- `abr_abort`  in  1  cancels a measurement. Takes priority over every other event.
- `rxd_in`  out  1  filtered serial data to `uart_rx`.
- `baud_rate_param`  out  16  bit-period parameter to `uart_rx`.
- `rx_hold`  out  1  equals `abr_busy`; keeps `uart_rx` idle.
- `abr_busy`  out  1  measurement in progress.
- `abr_done`  out  1  one-cycle pulse: measurement succeeded.
- `abr_error`  out  1  one-cycle pulse: measurement failed or was aborted.

## Operation
- **Input path.** Two-flop synchroniser `q1 <= rxd_pad; q2 <= q1`, then a history `h1 <= q2; h2 <= h1`, then `rxd_in <= maj(q2, h1, h2)`. All of these reset to 1.
- **Edge detect.** A one-cycle `fall` is asserted when `rxd_in_d == 1 && rxd_in == 0`. `rxd_in_d` resets to 1.
- **Software write.** When `param_wr && !abr_busy`, `baud_rate_param <= param_wdata` on the next edge.
- **FSM states:** IDLE, ARMED, MEASURE, WAIT_STOP.
  - IDLE: `abr_start` moves to ARMED.
  - ARMED: waits indefinitely for `fall` (start bit). On `fall`: `icnt <= 1`, `k <= 0`, `sum <= 0`, go to MEASURE.
  - MEASURE: `icnt` is 18 bits and increments every cycle. On `fall`, interval `I = icnt` is captured, then `icnt <= 1` and `k <= k + 1`.
    - k==0: store `I1 = I`, `sum = I`.
    - k=1..3: error if `|I − I1| > (I1 >> 2)`; otherwise `sum += I`.
    - After the 4th interval, go to WAIT_STOP.
    - If `icnt` reaches 18'h3FFFF before the next `fall`, error.
  - WAIT_STOP: waits for `rxd_in == 1` (stop bit). `icnt` keeps counting with the same saturation error. On stop bit, compute `p = ((sum + 4) >> 3) − 1`.
    - `sum` is 20 bits and `p` is computed at 20 bits.
    - Error if `p > 16'hFFFF` or `p < MIN_PARAM`.
    - Otherwise `baud_rate_param <= p[15:0]`, pulse `abr_done`, go to IDLE.
- **Error or abort.** Pulse `abr_error`, go to IDLE, leave `baud_rate_param` unchanged.
  - `abr_abort` in IDLE has no effect and produces no pulse.
  - Each aborted or failed measurement produces exactly one `abr_error`.
- **Busy.** `abr_busy = (state != IDLE)`.
- **Reset mid-measurement.** Returns to IDLE with all outputs at their reset values.

## Timing
- **Reset values:** `rxd_in` = 1, `baud_rate_param` = `DEFAULT_PARAM`, `rx_hold` = `abr_busy` = `abr_done` = `abr_error` = 0.
- **`rxd_pad` to `rxd_in`:** a clean level change on `rxd_pad` appears on `rxd_in` after the 4th rising edge. Latency is constant, so measured intervals are undistorted.
- **Glitch filter:** a pad pulse lasting 1 clock never reaches `rxd_in`. A pulse lasting 2 or more clocks passes with its width preserved.
- **`abr_start`:** `abr_busy` and `rx_hold` go high on the edge that samples `abr_start`.
- **Completion:** `abr_done` or `abr_error` is high for exactly one cycle. That is the same cycle in which `abr_busy` first reads 0 and the new `baud_rate_param` is visible.
- **Ideal 0x55 input** with bit period P clocks: every interval is 2P, `sum` = 8P, result `p` = P−1.
- **Simultaneous events:** `abr_abort` beats a stop bit or `fall` in the same cycle. `param_wr` in the `abr_done` cycle is accepted and overwrites the measured value on the following edge.

## Test plan
- **Reset:** hold `reset_n` low. Then `baud_rate_param` == 433, `rxd_in` == 1, and `abr_busy`, `abr_done`, `abr_error` == 0.
- **Glitch filter:** drive a 1-clock low pulse on `rxd_pad` → `rxd_in` stays 1. Drive a 3-clock low pulse → `rxd_in` is low for 3 cycles, starting 4 edges after the pulse.
- **Autobaud success:** `abr_start`, then 0x55 8N1 at P = 100 clocks → single `abr_done`, `baud_rate_param` == 99, `rx_hold` high throughout the measurement.
- **Jitter tolerance:** second interval = 250 with I1 = 200 → accepted (difference 50 ≤ 50). Second interval = 251 → `abr_error`, `baud_rate_param` unchanged.
- **Too fast:** 0x55 at P = 6 → `p` = 5 < 7 → `abr_error`.
- **Abort and write:** `abr_abort` asserted in MEASURE → `abr_error` pulse, IDLE. `param_wr` with 16'h1234 while busy is ignored; the same write in IDLE gives `baud_rate_param` == 16'h1234.

Source files
------------

// File: rtl/uart_autobaud.sv
// Receive front end for uart_rx: synchronises and glitch-filters RXD, owns
// baud_rate_param, and measures the bit period from a 0x55 sync character.
module uart_autobaud #(
  parameter logic [15:0] DEFAULT_PARAM = 16'd433,
  parameter logic [15:0] MIN_PARAM     = 16'd7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rxd_pad,
  input  logic        param_wr,
  input  logic [15:0] param_wdata,
  input  logic        abr_start,
  input  logic        abr_abort,
  output logic        rxd_in,
  output logic [15:0] baud_rate_param,
  output logic        rx_hold,
  output logic        abr_busy,
  output logic        abr_done,
  output logic        abr_error
);

  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, WAIT_STOP} state_t;

  localparam logic [17:0] ICNT_MAX = 18'h3FFFF;

  state_t      state;
  logic        q1, q2, h1, h2, rxd_in_d;
  logic [17:0] icnt;
  logic [17:0] i1;
  logic [1:0]  k;
  logic [19:0] sum;

  logic        fall;
  logic [17:0] diff;
  logic        jitter_bad;
  logic [19:0] p_full;
  logic        p_bad;

  // Valid/ready does not apply here: abr_start is a one-cycle request taken
  // only in IDLE; abr_done/abr_error are one-cycle completion pulses.

  assign fall       = rxd_in_d & ~rxd_in;
  assign diff       = (icnt >= i1) ? (icnt - i1) : (i1 - icnt);
  assign jitter_bad = diff > {2'b00, i1[17:2]};
  assign p_full     = ((sum + 20'd4) >> 3) - 20'd1;
  assign p_bad      = (p_full > 20'h0FFFF) || (p_full < {4'd0, MIN_PARAM});
  assign abr_busy   = (state != IDLE);
  assign rx_hold    = abr_busy;

  // Majority of three consecutive samples removes single-cycle glitches while
  // keeping a constant four-edge latency, so measured intervals stay exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q1       <= 1'b1;
      q2       <= 1'b1;
      h1       <= 1'b1;
      h2       <= 1'b1;
      rxd_in   <= 1'b1;
      rxd_in_d <= 1'b1;
    end else begin
      q1       <= rxd_pad;
      q2       <= q1;
      h1       <= q2;
      h2       <= h1;
      rxd_in   <= (q2 & h1) | (q2 & h2) | (h1 & h2);
      rxd_in_d <= rxd_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      baud_rate_param <= DEFAULT_PARAM;
      abr_done        <= 1'b0;
      abr_error       <= 1'b0;
      icnt            <= 18'd0;
      i1              <= 18'd0;
      k               <= 2'd0;
      sum             <= 20'd0;
    end else begin
      abr_done  <= 1'b0;
      abr_error <= 1'b0;
      if (state != IDLE && abr_abort) begin
        abr_error <= 1'b1;
        state     <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (param_wr) baud_rate_param <= param_wdata;
            if (abr_start) state <= ARMED;
          end
          ARMED: begin
            if (fall) begin
              icnt  <= 18'd1;
              k     <= 2'd0;
              sum   <= 20'd0;
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (fall) begin
              icnt <= 18'd1;
              k    <= k + 2'd1;
              if (k == 2'd0) begin
                i1  <= icnt;
                sum <= {2'b00, icnt};
              end else if (jitter_bad) begin
                abr_error <= 1'b1;
                state     <= IDLE;
              end else begin
                sum <= sum + {2'b00, icnt};
                if (k == 2'd3) state <= WAIT_STOP;
              end
            end else if (icnt == ICNT_MAX) begin
              abr_error <= 1'b1;
              state     <= IDLE;
            end else begin
              icnt <= icnt + 18'd1;
            end
          end
          WAIT_STOP: begin
            if (rxd_in) begin
              if (p_bad) begin
                abr_error <= 1'b1;
              end else begin
                baud_rate_param <= p_full[15:0];
                abr_done        <= 1'b1;
              end
              state <= IDLE;
            end else if (icnt == ICNT_MAX) begin
              abr_error <= 1'b1;
              state     <= IDLE;
            end else begin
              icnt <= icnt + 18'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: reset, glitch filter, a table of sync
// frames with hand-computed results, then abort and software-write sequences.
module tb_uart_autobaud;

  logic        clk;
  logic        reset_n;
  logic        rxd_pad;
  logic        param_wr;
  logic [15:0] param_wdata;
  logic        abr_start;
  logic        abr_abort;
  logic        rxd_in;
  logic [15:0] baud_rate_param;
  logic        rx_hold;
  logic        abr_busy;
  logic        abr_done;
  logic        abr_error;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int hold_bad = 0;

  uart_autobaud dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rxd_pad         (rxd_pad),
    .param_wr        (param_wr),
    .param_wdata     (param_wdata),
    .abr_start       (abr_start),
    .abr_abort       (abr_abort),
    .rxd_in          (rxd_in),
    .baud_rate_param (baud_rate_param),
    .rx_hold         (rx_hold),
    .abr_busy        (abr_busy),
    .abr_done        (abr_done),
    .abr_error       (abr_error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // completion-pulse and hold monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (abr_done) done_cnt++;
      if (abr_error) err_cnt++;
      if (rx_hold !== abr_busy) hold_bad++;
    end
  end

  typedef struct {
    int          low_len;
    int          iv0, iv1, iv2, iv3;
    bit          busy_pre_stop;
    int          exp_done;
    int          exp_err;
    logic [15:0] exp_param;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers: every task starts and ends 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pad_for(input logic v, input int n);
    rxd_pad = v;
    step(n);
  endtask

  task automatic pulse_start();
    abr_start = 1'b1;
    step(1);
    abr_start = 1'b0;
  endtask

  task automatic pulse_abort();
    abr_abort = 1'b1;
    step(1);
    abr_abort = 1'b0;
  endtask

  task automatic write_param(input logic [15:0] d);
    param_wr    = 1'b1;
    param_wdata = d;
    step(1);
    param_wr    = 1'b0;
  endtask

  task automatic send_interval(input int l, input int iv);
    pad_for(1'b0, l);
    pad_for(1'b1, iv - l);
  endtask

  initial begin
    int d0, e0, first_low, low_cnt;
    bit glitch_seen;

    // frames as seen on the pad: low_len, four falling-edge intervals, busy
    // just before the stop bit, done/error pulse counts, resulting parameter
    vecs[0] = '{100, 200, 200, 200, 200, 1'b1, 1, 0, 16'd99};  // P=100
    vecs[1] = '{6,   12,  12,  12,  12,  1'b1, 0, 1, 16'd99};  // P=6, p=5 < 7
    vecs[2] = '{100, 200, 250, 200, 200, 1'b1, 1, 0, 16'd105}; // diff 50, sum 850
    vecs[3] = '{100, 200, 251, 200, 200, 1'b0, 0, 1, 16'd105}; // diff 51
    vecs[4] = '{20,  40,  40,  40,  40,  1'b1, 1, 0, 16'd19};  // P=20
    vecs[5] = '{100, 200, 150, 200, 200, 1'b1, 1, 0, 16'd93};  // diff -50, sum 750
    vecs[6] = '{8,   16,  16,  16,  16,  1'b1, 1, 0, 16'd7};   // p == MIN

    reset_n     = 1'b0;
    rxd_pad     = 1'b1;
    param_wr    = 1'b0;
    param_wdata = 16'h0000;
    abr_start   = 1'b0;
    abr_abort   = 1'b0;
    step(3);

    check("reset_param", baud_rate_param, 16'd433);
    check("reset_rxd_in", rxd_in, 1'b1);
    check("reset_busy", abr_busy, 1'b0);
    check("reset_done", abr_done, 1'b0);
    check("reset_error", abr_error, 1'b0);
    check("reset_hold", rx_hold, 1'b0);

    reset_n = 1'b1;
    step(5);

    // 1-clock low pulse must be filtered out
    glitch_seen = 1'b0;
    pad_for(1'b0, 1);
    rxd_pad = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (rxd_in !== 1'b1) glitch_seen = 1'b1;
    end
    check("glitch_1clk", glitch_seen, 1'b0);

    // 3-clock low pulse: low after edges 4..6 counted from the drive point
    first_low = -1;
    low_cnt   = 0;
    rxd_pad   = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) rxd_pad = 1'b1;
      if (rxd_in === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = i;
      end
    end
    check("glitch_3clk_start", first_low, 4);
    check("glitch_3clk_width", low_cnt, 3);
    step(5);

    // table-driven sync frames
    for (int v = 0; v < 7; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      pulse_start();
      check($sformatf("v%0d_busy_after_start", v), abr_busy, 1'b1);
      send_interval(vecs[v].low_len, vecs[v].iv0);
      send_interval(vecs[v].low_len, vecs[v].iv1);
      send_interval(vecs[v].low_len, vecs[v].iv2);
      send_interval(vecs[v].low_len, vecs[v].iv3);
      pad_for(1'b0, vecs[v].low_len);
      check($sformatf("v%0d_busy_pre_stop", v), abr_busy, vecs[v].busy_pre_stop);
      pad_for(1'b1, 20);
      check($sformatf("v%0d_done_pulses", v), done_cnt - d0, vecs[v].exp_done);
      check($sformatf("v%0d_error_pulses", v), err_cnt - e0, vecs[v].exp_err);
      check($sformatf("v%0d_param", v), baud_rate_param, vecs[v].exp_param);
      check($sformatf("v%0d_idle", v), abr_busy, 1'b0);
    end

    // abort in MEASURE
    e0 = err_cnt;
    d0 = done_cnt;
    pulse_start();
    pad_for(1'b0, 12);
    check("abort_busy_before", abr_busy, 1'b1);
    pulse_abort();
    check("abort_error_now", abr_error, 1'b1);
    check("abort_busy_after", abr_busy, 1'b0);
    pad_for(1'b1, 10);
    check("abort_error_pulses", err_cnt - e0, 1);
    check("abort_done_pulses", done_cnt - d0, 0);
    check("abort_param", baud_rate_param, 16'd7);

    // abort in IDLE: no pulse
    e0 = err_cnt;
    pulse_abort();
    step(3);
    check("idle_abort_pulses", err_cnt - e0, 0);

    // software write ignored while busy, accepted in IDLE
    pulse_start();
    write_param(16'h1234);
    check("write_busy_ignored", baud_rate_param, 16'd7);
    pulse_abort();
    step(2);
    write_param(16'h1234);
    check("write_idle", baud_rate_param, 16'h1234);

    check("hold_equals_busy", hold_bad, 0);

    // reset in the middle of a measurement
    pulse_start();
    pad_for(1'b0, 10);
    reset_n = 1'b0;
    #2;
    check("midreset_busy", abr_busy, 1'b0);
    check("midreset_param", baud_rate_param, 16'd433);
    check("midreset_rxd_in", rxd_in, 1'b1);
    rxd_pad = 1'b1;
    step(2);
    reset_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
